// File: rtl/nco_pkg.sv
// Shared types and defaults for the NCO frequency-sweep controller.
package nco_pkg;

    localparam int NCO_WIDTH   = 64;
    localparam int NCO_DWELL_W = 16;

    typedef logic [NCO_WIDTH-1:0] phase_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_FINAL,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a dwell.
module sweep_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps the carrier NCO phase increment from start to stop, holding each value
// for a programmable dwell, with optional looping and abort.
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int WIDTH   = NCO_WIDTH,
    parameter int DWELL_W = NCO_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_start_inc,
    input  logic [WIDTH-1:0]   cfg_stop_inc,
    input  logic [WIDTH-1:0]   cfg_step_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               abort,
    output logic [WIDTH-1:0]   phase_inc_carr,
    output logic               busy,
    output logic               done
);

    sweep_state_t       state;
    logic [WIDTH-1:0]   start_q;
    logic [WIDTH-1:0]   stop_q;
    logic [WIDTH-1:0]   step_q;
    logic [DWELL_W-1:0] reload_q;
    logic               loop_q;
    logic               degen_q;

    logic               accept;
    logic [DWELL_W-1:0] cfg_reload;
    logic [WIDTH:0]     sum;
    logic               sum_lt_stop;
    logic               in_run;
    logic               t_load;
    logic               t_dec;
    logic [DWELL_W-1:0] t_val;
    logic               dwell_zero;

    assign accept      = cfg_valid && cfg_ready;
    assign cfg_reload  = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    // One extra bit so a carry out of WIDTH bits still compares as >= stop.
    assign sum         = {1'b0, phase_inc_carr} + {1'b0, step_q};
    assign sum_lt_stop = sum < {1'b0, stop_q};
    assign in_run      = (state == ST_DWELL) || (state == ST_FINAL);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        t_load = 1'b0;
        t_dec  = 1'b0;
        t_val  = '0;
        if (state == ST_IDLE) begin
            if (accept) begin
                t_load = 1'b1;
                t_val  = cfg_reload;
            end
        end else if (abort) begin
            t_load = 1'b1;
        end else if (in_run) begin
            if (dwell_zero) begin
                t_load = 1'b1;
                t_val  = reload_q;
            end else begin
                t_dec = 1'b1;
            end
        end
    end

    sweep_dwell_timer #(
        .W(DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (t_load),
        .load_val(t_val),
        .dec     (t_dec),
        .zero    (dwell_zero)
    );

    // NOTE: the latched configuration is reset too, so a reset mid-sweep leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            phase_inc_carr <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_ready      <= 1'b0;
            start_q        <= '0;
            stop_q         <= '0;
            step_q         <= '0;
            reload_q       <= '0;
            loop_q         <= 1'b0;
            degen_q        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state          <= ST_IDLE;
                phase_inc_carr <= '0;
                busy           <= 1'b0;
                cfg_ready      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            start_q        <= cfg_start_inc;
                            stop_q         <= cfg_stop_inc;
                            step_q         <= cfg_step_inc;
                            reload_q       <= cfg_reload;
                            loop_q         <= cfg_loop;
                            degen_q        <= (cfg_step_inc == '0) || (cfg_start_inc >= cfg_stop_inc);
                            phase_inc_carr <= cfg_start_inc;
                            state          <= ST_DWELL;
                            busy           <= 1'b1;
                            cfg_ready      <= 1'b0;
                        end else begin
                            cfg_ready <= 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (dwell_zero) begin
                            if (degen_q) begin
                                if (loop_q) begin
                                    phase_inc_carr <= start_q;
                                end else begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end
                            end else if (sum_lt_stop) begin
                                phase_inc_carr <= sum[WIDTH-1:0];
                            end else begin
                                phase_inc_carr <= stop_q;
                                state          <= ST_FINAL;
                            end
                        end
                    end
                    ST_FINAL: begin
                        if (dwell_zero) begin
                            if (loop_q) begin
                                phase_inc_carr <= start_q;
                                state          <= ST_DWELL;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
